// File: rtl/bp_l15_inval_arbiter.sv
// L1.5 EVICT_REQ to dcache tag-invalidate return path, muxed with fill tag packets.
// Optional macro BP_L15_INVAL_ALL_WAY_EN enables the all-way invalidate walk.
module bp_l15_inval_arbiter #(
    parameter int lce_sets_p        = 64,
    parameter int lce_assoc_p       = 8,
    parameter int ptag_width_p      = 28,
    parameter int data_pkt_width_p  = 523,
    parameter int stat_pkt_width_p  = 11,
    localparam int sets_w_lp        = $clog2(lce_sets_p),
    localparam int way_w_lp         = $clog2(lce_assoc_p),
    localparam int tag_pkt_width_lp = sets_w_lp + way_w_lp + ptag_width_p + 5
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        l15_transducer_val,
    input  logic [3:0]                  l15_transducer_returntype,
    input  logic [11:0]                 l15_transducer_inval_address_15_4,
    input  logic                        l15_transducer_inval_dcache_inval,
    input  logic                        l15_transducer_inval_dcache_all_way,
    input  logic [1:0]                  l15_transducer_inval_way,
    output logic                        inval_l15_req_ack_o,
    input  logic [data_pkt_width_p-1:0] fill_data_pkt_i,
    input  logic                        fill_data_pkt_v_i,
    output logic                        fill_data_pkt_yumi_o,
    input  logic [tag_pkt_width_lp-1:0] fill_tag_pkt_i,
    input  logic                        fill_tag_pkt_v_i,
    output logic                        fill_tag_pkt_yumi_o,
    input  logic [stat_pkt_width_p-1:0] fill_stat_pkt_i,
    input  logic                        fill_stat_pkt_v_i,
    output logic                        fill_stat_pkt_yumi_o,
    output logic [data_pkt_width_p-1:0] data_mem_pkt_o,
    output logic                        data_mem_pkt_v_o,
    input  logic                        data_mem_pkt_yumi_i,
    output logic [tag_pkt_width_lp-1:0] tag_mem_pkt_o,
    output logic                        tag_mem_pkt_v_o,
    input  logic                        tag_mem_pkt_yumi_i,
    output logic [stat_pkt_width_p-1:0] stat_mem_pkt_o,
    output logic                        stat_mem_pkt_v_o,
    input  logic                        stat_mem_pkt_yumi_i,
    output logic                        inval_err_o
);

    localparam logic [3:0] EVICT_REQ = 4'b0011;

    typedef enum logic [1:0] {
        e_dcache_lce_tag_mem_set_clear,
        e_dcache_lce_tag_mem_invalidate,
        e_dcache_lce_tag_mem_set_tag,
        e_dcache_lce_tag_mem_set_state
    } tag_op_e;

    typedef struct packed {
        logic [sets_w_lp-1:0]    index;
        logic [way_w_lp-1:0]     way_id;
        logic [ptag_width_p-1:0] tag;
        logic [2:0]              state;
        tag_op_e                 opcode;
    } tag_pkt_s;

    typedef enum logic {e_idle, e_send} state_e;

    state_e               state_q;
    logic [way_w_lp-1:0]  way_q;
    logic [sets_w_lp-1:0] index_q;
    logic                 all_q;
    logic                 err_q;

    logic evict_v, accept, dcache_req, all_req, err_req;
    tag_pkt_s inval_pkt;

    logic unused_addr;
    assign unused_addr = ^l15_transducer_inval_address_15_4[5:0];

    assign data_mem_pkt_o       = fill_data_pkt_i;
    assign data_mem_pkt_v_o     = fill_data_pkt_v_i;
    assign fill_data_pkt_yumi_o = data_mem_pkt_yumi_i;
    assign stat_mem_pkt_o       = fill_stat_pkt_i;
    assign stat_mem_pkt_v_o     = fill_stat_pkt_v_i;
    assign fill_stat_pkt_yumi_o = stat_mem_pkt_yumi_i;

    assign evict_v    = l15_transducer_val
                      & (l15_transducer_returntype == EVICT_REQ);
    // A presented fill tag packet always wins; L1.5 keeps val high.
    assign accept     = reset_n_i & (state_q == e_idle)
                      & evict_v & ~fill_tag_pkt_v_i;
    assign dcache_req = l15_transducer_inval_dcache_inval
                      | l15_transducer_inval_dcache_all_way;
`ifdef BP_L15_INVAL_ALL_WAY_EN
    assign all_req = l15_transducer_inval_dcache_all_way;
    assign err_req = 1'b0;
`else
    assign all_req = 1'b0;
    assign err_req = l15_transducer_inval_dcache_all_way;
`endif

    assign inval_l15_req_ack_o = accept;
    assign inval_err_o         = err_q;

    always_comb begin
        inval_pkt        = '0;
        inval_pkt.index  = index_q;
        inval_pkt.way_id = way_q;
        inval_pkt.opcode = e_dcache_lce_tag_mem_invalidate;
        if (state_q == e_send) begin
            tag_mem_pkt_o       = inval_pkt;
            tag_mem_pkt_v_o     = 1'b1;
            fill_tag_pkt_yumi_o = 1'b0;
        end else begin
            tag_mem_pkt_o       = fill_tag_pkt_i;
            tag_mem_pkt_v_o     = fill_tag_pkt_v_i;
            fill_tag_pkt_yumi_o = tag_mem_pkt_yumi_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= e_idle;
            way_q   <= '0;
            index_q <= '0;
            all_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                e_idle: begin
                    if (accept) begin
                        index_q <= l15_transducer_inval_address_15_4[11:6];
                        if (err_req) err_q <= 1'b1;
                        if (dcache_req) begin
                            way_q   <= all_req ? '0
                                     : {1'b0, l15_transducer_inval_way};
                            all_q   <= all_req;
                            state_q <= e_send;
                        end
                    end
                end
                e_send: begin
                    if (tag_mem_pkt_yumi_i) begin
                        if (all_q && (way_q != 3'd7)) begin
                            way_q <= way_q + 3'd1;
                        end else begin
                            state_q <= e_idle;
                        end
                    end
                end
                default: state_q <= e_idle;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_l15_inval_arbiter.sv
// Scoreboard bench for bp_l15_inval_arbiter: tag handshakes checked by a monitor.
// Honours BP_L15_INVAL_ALL_WAY_EN to pick the all-way expectations.
module tb_bp_l15_inval_arbiter;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         val;
    logic [3:0]   rt;
    logic [11:0]  addr;
    logic         dinval, allway;
    logic [1:0]   way;
    logic         ack;
    logic [522:0] fd_pkt, d_pkt;
    logic         fd_v, fd_yumi, d_v, d_yumi;
    logic [41:0]  ft_pkt, t_pkt;
    logic         ft_v, ft_yumi, t_v, t_yumi;
    logic [10:0]  fs_pkt, s_pkt;
    logic         fs_v, fs_yumi, s_v, s_yumi;
    logic         err;

    int checks = 0;
    int errors = 0;
    logic [41:0] exp_q[$];

    always #5 clk = ~clk;

    bp_l15_inval_arbiter dut (
        .clk_i                               (clk),
        .reset_n_i                           (reset_n),
        .l15_transducer_val                  (val),
        .l15_transducer_returntype           (rt),
        .l15_transducer_inval_address_15_4   (addr),
        .l15_transducer_inval_dcache_inval   (dinval),
        .l15_transducer_inval_dcache_all_way (allway),
        .l15_transducer_inval_way            (way),
        .inval_l15_req_ack_o                 (ack),
        .fill_data_pkt_i                     (fd_pkt),
        .fill_data_pkt_v_i                   (fd_v),
        .fill_data_pkt_yumi_o                (fd_yumi),
        .fill_tag_pkt_i                      (ft_pkt),
        .fill_tag_pkt_v_i                    (ft_v),
        .fill_tag_pkt_yumi_o                 (ft_yumi),
        .fill_stat_pkt_i                     (fs_pkt),
        .fill_stat_pkt_v_i                   (fs_v),
        .fill_stat_pkt_yumi_o                (fs_yumi),
        .data_mem_pkt_o                      (d_pkt),
        .data_mem_pkt_v_o                    (d_v),
        .data_mem_pkt_yumi_i                 (d_yumi),
        .tag_mem_pkt_o                       (t_pkt),
        .tag_mem_pkt_v_o                     (t_v),
        .tag_mem_pkt_yumi_i                  (t_yumi),
        .stat_mem_pkt_o                      (s_pkt),
        .stat_mem_pkt_v_o                    (s_v),
        .stat_mem_pkt_yumi_i                 (s_yumi),
        .inval_err_o                         (err)
    );

    // {index, way, tag=0, state=0, opcode=invalidate(1)}
    function automatic logic [41:0] mk_inval(input logic [5:0] idx,
                                             input logic [2:0] w);
        return {idx, w, 28'd0, 3'd0, 2'd1};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic evict(input logic [11:0] a, input logic di,
                         input logic aw, input logic [1:0] w);
        val = 1'b1; rt = 4'b0011; addr = a;
        dinval = di; allway = aw; way = w;
    endtask

    task automatic pt_check;
        logic [522:0] d;
        logic [10:0]  s;
        logic [3:0]   r;
        for (int i = 0; i < 523; i++) d[i] = 1'($urandom_range(1, 0));
        s = 11'($urandom);
        r = 4'($urandom);
        fd_pkt = d; fs_pkt = s;
        fd_v = r[0]; d_yumi = r[1]; fs_v = r[2]; s_yumi = r[3];
        #1;
        checks++;
        if (d_pkt !== d) begin
            errors++;
            $display("FAIL data_pkt act=%0h exp=%0h", d_pkt[63:0], d[63:0]);
        end
        chk("stat_pkt", 64'(s_pkt), 64'(s));
        chk("pt_flags", {60'd0, fd_yumi, s_yumi, d_v, s_v},
            {60'd0, r[1], r[3], r[0], r[2]});
    endtask

    // Scoreboard monitor: every accepted tag packet must match the queue head.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && t_v === 1'b1 && t_yumi === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tag_pkt unexpected act=%0h exp=none", t_pkt);
            end else begin
                logic [41:0] e;
                e = exp_q.pop_front();
                if (t_pkt !== e) begin
                    errors++;
                    $display("FAIL tag_pkt act=%0h exp=%0h", t_pkt, e);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0; val = 1'b0; rt = 4'd0; addr = '0;
        dinval = 1'b0; allway = 1'b0; way = 2'd0;
        fd_pkt = '0; fd_v = 1'b1; d_yumi = 1'b1;
        ft_pkt = '0; ft_v = 1'b0; t_yumi = 1'b0;
        fs_pkt = '0; fs_v = 1'b1; s_yumi = 1'b0;
        step; step;
        @(negedge clk);
        chk("rst_tag_v", 64'(t_v), 64'd0);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_pt", {61'd0, d_v, fd_yumi, s_v}, {61'd0, 3'b111});
        step;
        reset_n = 1'b1; fd_v = 1'b0; d_yumi = 1'b0; fs_v = 1'b0;

        // Single-way, then icache-only EVICT held during e_send
        step;
        evict(12'hF00, 1'b1, 1'b0, 2'd2);
        @(negedge clk);
        chk("single_ack_T", 64'(ack), 64'd1);
        exp_q.push_back(mk_inval(6'h3C, 3'd2));
        step;
        evict(12'h040, 1'b0, 1'b0, 2'd1);
        t_yumi = 1'b1;
        @(negedge clk);
        chk("single_v_T1", 64'(t_v), 64'd1);
        chk("no_ack_in_send", 64'(ack), 64'd0);
        step;
        t_yumi = 1'b0;
        @(negedge clk);
        chk("icache_ack_T2", 64'(ack), 64'd1);
        chk("single_done_v", 64'(t_v), 64'd0);
        step;
        val = 1'b0;
        @(negedge clk);
        chk("icache_no_pkt", 64'(t_v), 64'd0);
        step;
        val = 1'b1; rt = 4'b0000; dinval = 1'b1;
        @(negedge clk);
        chk("load_ret_no_ack", 64'(ack), 64'd0);
        step;
        val = 1'b0;

        // All-way request, index 5, way 3, yumi held
        step;
        evict(12'h140, 1'b0, 1'b1, 2'd3);
        @(negedge clk);
        chk("all_ack", 64'(ack), 64'd1);
`ifdef BP_L15_INVAL_ALL_WAY_EN
        for (int w = 0; w < 8; w++) exp_q.push_back(mk_inval(6'd5, 3'(w)));
        step;
        val = 1'b0; t_yumi = 1'b1;
        for (int w = 0; w < 8; w++) begin
            @(negedge clk);
            chk("all_walk_v", 64'(t_v), 64'd1);
            step;
        end
        t_yumi = 1'b0;
        @(negedge clk);
        chk("all_done_v", 64'(t_v), 64'd0);
        chk("all_err", 64'(err), 64'd0);
`else
        exp_q.push_back(mk_inval(6'd5, 3'd3));
        step;
        val = 1'b0; t_yumi = 1'b1;
        @(negedge clk);
        chk("all_single_v", 64'(t_v), 64'd1);
        step;
        t_yumi = 1'b0;
        @(negedge clk);
        chk("all_single_done", 64'(t_v), 64'd0);
        chk("all_err", 64'(err), 64'd1);
        step; step;
        @(negedge clk);
        chk("all_err_sticky", 64'(err), 64'd1);
`endif
        step;

        // Conflict: fill tag wins, EVICT acked after fill yumi
        ft_pkt = 42'h2_ABCD_EF01; ft_v = 1'b1;
        exp_q.push_back(42'h2_ABCD_EF01);
        evict(12'h1C0, 1'b1, 1'b0, 2'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("conf_ack", 64'(ack), 64'd0);
            chk("conf_fwd", 64'(t_pkt), 64'h2_ABCD_EF01);
            chk("conf_yumi", 64'(ft_yumi), 64'd0);
            step;
        end
        t_yumi = 1'b1;
        @(negedge clk);
        chk("conf_ack_y", 64'(ack), 64'd0);
        chk("conf_yumi_y", 64'(ft_yumi), 64'd1);
        step;
        ft_v = 1'b0; t_yumi = 1'b0;
        @(negedge clk);
        chk("conf_ack_after", 64'(ack), 64'd1);
        exp_q.push_back(mk_inval(6'd7, 3'd1));
        step;
        val = 1'b0; t_yumi = 1'b1;
        @(negedge clk);
        chk("conf_inv_v", 64'(t_v), 64'd1);
        chk("conf_fill_blk", 64'(ft_yumi), 64'd0);
        step;
        t_yumi = 1'b0;

        // Pass-through during a walk, then reset mid-walk
        step;
        evict(12'h240, 1'b1, 1'b1, 2'd0);
        @(negedge clk);
        chk("rw_ack", 64'(ack), 64'd1);
        begin
            int k;
`ifdef BP_L15_INVAL_ALL_WAY_EN
            k = 3;
            for (int w = 0; w < 3; w++) exp_q.push_back(mk_inval(6'd9, 3'(w)));
`else
            k = 0;
`endif
            step;
            val = 1'b0; t_yumi = (k > 0);
            for (int i = 0; i < k; i++) begin
                pt_check();
                @(negedge clk);
                chk("rw_walk_v", 64'(t_v), 64'd1);
                step;
            end
        end
        t_yumi = 1'b0; reset_n = 1'b0;
        pt_check();
        @(negedge clk);
        chk("rw_v_pre", 64'(t_v), 64'd1);
        chk("rw_ack_rst", 64'(ack), 64'd0);
        step;
        @(negedge clk);
        chk("rw_v_post", 64'(t_v), 64'd0);
        chk("rw_err_clr", 64'(err), 64'd0);
        step;
        reset_n = 1'b1;
        step; step;
        @(negedge clk);
        chk("rw_idle", 64'(t_v), 64'd0);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
